// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with a registered result and a Z/N/C/V flag register.
// Optional iterative shifter for opcodes 1011-1101 is built when `ALU_SEQ_SHIFT_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             ci_sel,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1
`ifdef ALU_SEQ_SHIFT_EN
        , SHIFT = 2'd2
`endif
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] out_q;
    logic             z_q, n_q, c_q, v_q;

    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             cv_wr;
    logic             v_d;

    assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign out_valid = (state_q == HOLD);
    assign out       = out_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;

`ifdef ALU_SEQ_SHIFT_EN
    logic             is_shift;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       sop_q;
    logic             sf_q;
    logic             sh_co;

    // sop_q holds op[1:0]: 11 = SHL, 00 = SHR, 01 = SRA
    always_comb begin
        sh_d  = sh_q;
        sh_co = 1'b0;
        case (sop_q)
            2'b11:   {sh_co, sh_d} = {sh_q, 1'b0};
            2'b00:   {sh_d, sh_co} = {1'b0, sh_q};
            default: {sh_d, sh_co} = {sh_q[WIDTH-1], sh_q};
        endcase
    end
`endif

    // Arithmetic is one bit wider so bit WIDTH is carry (add) or borrow (sub).
    always_comb begin
        cin = ci_sel ? c_q : ci;
        sum = '0;
`ifdef ALU_SEQ_SHIFT_EN
        is_shift = 1'b0;
`endif
        case (op)
            4'b0000: sum = {1'b0, a} + {1'b0, b};
            4'b0001: sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            4'b0010: sum = {1'b0, a} - {1'b0, b};
            4'b0011: sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            4'b0100: sum = {1'b0, b} - {1'b0, a};
            4'b0101: sum = {1'b0, a | b};
            4'b0110: sum = {1'b0, a ^ b};
            4'b0111: sum = {1'b0, a & b};
            4'b1000: sum = {1'b0, a};
            4'b1001: sum = {1'b0, a} + (WIDTH+1)'(8);
            4'b1010: sum = {1'b0, b};
`ifdef ALU_SEQ_SHIFT_EN
            4'b1011, 4'b1100, 4'b1101: begin
                sum      = {1'b0, a};
                is_shift = 1'b1;
            end
`endif
            default: sum = '0;
        endcase
        res   = sum[WIDTH-1:0];
        cv_wr = (op[3:2] == 2'b00);
        v_d   = op[1] ? ((a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ res[WIDTH-1]))
                      : (~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ res[WIDTH-1]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
            sh_q    <= '0;
            cnt_q   <= '0;
            sop_q   <= '0;
            sf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
`ifdef ALU_SEQ_SHIFT_EN
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        out_q   <= sh_d;
                        state_q <= HOLD;
                        if (sf_q) begin
                            z_q <= (sh_d == '0);
                            n_q <= sh_d[WIDTH-1];
                            c_q <= sh_co;
                        end
                    end
                end
`endif
                default: begin
                    if (in_valid && in_ready) begin
`ifdef ALU_SEQ_SHIFT_EN
                        if (is_shift && b[SHW-1:0] != '0) begin
                            state_q <= SHIFT;
                            sh_q    <= a;
                            cnt_q   <= b[SHW-1:0];
                            sop_q   <= op[1:0];
                            sf_q    <= set_flags;
                        end else
`endif
                        begin
                            state_q <= HOLD;
                            out_q   <= res;
                            if (set_flags) begin
                                z_q <= (res == '0);
                                n_q <= res[WIDTH-1];
                                if (cv_wr) begin
                                    c_q <= sum[WIDTH];
                                    v_q <= v_d;
                                end
                            end
                        end
                    end else if (state_q == HOLD && out_ready) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of predicted results/flags, popped on each output handshake.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         ci_sel = 1'b0;
    logic         set_flags = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         z, n, c, v;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .ci(ci), .ci_sel(ci_sel), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .z(z), .n(n), .c(c), .v(v)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         z, n, c, v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   fz, fn, fc, fv;
    bit   popped, accepted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic and native shift operators.
    function automatic exp_t predict(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                     input bit cc, input bit cs, input bit sf);
        exp_t         e;
        logic [W-1:0] r;
        logic [63:0]  t;
        bit           cin, nc, nv;
`ifdef ALU_SEQ_SHIFT_EN
        int           sh;
        sh = int'(bb[4:0]);
`endif
        cin = cs ? fc : cc;
        nc  = fc;
        nv  = fv;
        r   = '0;
        t   = '0;
        case (o)
            4'h0, 4'h1: begin
                t  = 64'(aa) + 64'(bb) + ((o == 4'h1) ? 64'(cin) : 64'd0);
                r  = t[W-1:0];
                nc = t[W];
                nv = (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
            end
            4'h2, 4'h3: begin
                t  = 64'(bb) + ((o == 4'h3) ? 64'(cin) : 64'd0);
                r  = aa - t[W-1:0];
                nc = (64'(aa) < t);
                nv = (aa[W-1] != bb[W-1]) && (r[W-1] != aa[W-1]);
            end
            4'h4: r = bb - aa;
            4'h5: r = aa | bb;
            4'h6: r = aa ^ bb;
            4'h7: r = aa & bb;
            4'h8: r = aa;
            4'h9: r = aa + 32'd8;
            4'hA: r = bb;
`ifdef ALU_SEQ_SHIFT_EN
            4'hB: begin r = aa << sh; if (sh != 0) nc = aa[W - sh]; end
            4'hC: begin r = aa >> sh; if (sh != 0) nc = aa[sh - 1]; end
            4'hD: begin r = $signed(aa) >>> sh; if (sh != 0) nc = aa[sh - 1]; end
`endif
            default: r = '0;
        endcase
        if (sf) begin
            fz = (r == '0);
            fn = r[W-1];
            fc = nc;
            fv = nv;
        end
        e.r = r; e.z = fz; e.n = fn; e.c = fc; e.v = fv;
        return e;
    endfunction

    // One cycle: drive after the falling edge, then judge the handshakes the next rising edge will see.
    task automatic drive(input bit iv, input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit cc, input bit cs, input bit sf, input bit ordy);
        exp_t e;
        @(negedge clk);
        in_valid = iv; op = o; a = aa; b = bb; ci = cc; ci_sel = cs; set_flags = sf; out_ready = ordy;
        #1;
        popped   = 1'b0;
        accepted = 1'b0;
        if (out_valid && out_ready) begin
            popped = 1'b1;
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res_out", out, e.r);
                chk("res_flags", 32'({z, n, c, v}), 32'({e.z, e.n, e.c, e.v}));
            end
        end
        if (in_valid && in_ready) begin
            accepted = 1'b1;
            sb.push_back(predict(o, aa, bb, cc, cs, sf));
        end
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    task automatic wait_out(input string tag, input int lat, input bit busy);
        int k;
        k = 0;
        do begin
            idle(1'b1);
            k++;
            if (busy && !popped) chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        end while (!popped && k < 100);
        chk({tag, "_latency"}, 32'(k), 32'(lat));
    endtask

    logic [3:0]   t_op[8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h9, 4'h1, 4'hA, 4'hE};
    logic [W-1:0] t_a[8]  = '{32'h7FFFFFFF, 32'h0, 32'h5, 32'h3, 32'hFFFFFFF8, 32'h1, 32'h1234, 32'hFFFF};
    logic [W-1:0] t_b[8]  = '{32'h1, 32'h1, 32'h5, 32'hA, 32'h0, 32'h1, 32'h5678, 32'hFFFF};
    bit           t_ci[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit           t_cs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]   r_ops[13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hE, 4'hF};

    initial begin
        int stale;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", out, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'({z, n, c, v}), 32'd0);
        rst_n = 1'b1;

        drive(1'b1, 4'h0, 32'h9C000038, 32'h70000003, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("add_accept", 32'(accepted), 32'd1);
        wait_out("add", 1, 1'b0);
        chk("add_out", out, 32'h0C00003B);
        chk("add_flags", 32'({z, n, c, v}), 32'h2);

        drive(1'b1, 4'h2, 32'h9C000038, 32'h70000003, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("sub", 1, 1'b0);
        chk("sub_out", out, 32'h2C000035);
        chk("sub_flags", 32'({z, n, c, v}), 32'h1);

        drive(1'b1, 4'h1, 32'h9C000038, 32'h70000003, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_out("adc", 1, 1'b0);
        chk("adc_out", out, 32'h0C00003B);

        drive(1'b1, 4'h7, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("and", 1, 1'b0);
        chk("and_out", out, 32'h0);
        chk("and_flags", 32'({z, n, c, v}), 32'hA);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, t_op[i], t_a[i], t_b[i], t_ci[i], t_cs[i], 1'b1, 1'b1);
            chk("b2b_accept", 32'(accepted), 32'd1);
            if (i > 0) chk("b2b_pop", 32'(popped), 32'd1);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, r_ops[$urandom_range(0, 12)], $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            chk("rnd_accept", 32'(accepted), 32'd1);
        end
        wait_out("drain", 1, 1'b0);

`ifdef ALU_SEQ_SHIFT_EN
        drive(1'b1, 4'hB, 32'h1, 32'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("shl", 5, 1'b1);
        chk("shl_out", out, 32'h10);
        drive(1'b1, 4'hD, 32'h80000000, 32'd31, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("sra", 32, 1'b1);
        chk("sra_out", out, 32'hFFFFFFFF);
        chk("sra_n", 32'(n), 32'd1);
        drive(1'b1, 4'hC, 32'h3, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("shr", 2, 1'b1);
        drive(1'b1, 4'hC, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("shr0", 1, 1'b0);
`else
        drive(1'b1, 4'hB, 32'h1, 32'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_out("shl_off", 1, 1'b0);
        chk("shl_off_out", out, 32'h0);
        chk("shl_off_z", 32'(z), 32'd1);
`endif

        drive(1'b1, 4'h0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_first_accept", 32'(accepted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h6, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_no_accept", 32'(accepted), 32'd0);
            chk("bp_out", out, 32'h0);
            chk("bp_flags", 32'({z, n, c, v}), 32'hA);
        end
        drive(1'b1, 4'h6, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp_release_pop", 32'(popped), 32'd1);
        chk("bp_release_accept", 32'(accepted), 32'd1);
        wait_out("bp_next", 1, 1'b0);
        chk("bp_next_out", out, 32'hAAAAAAAA);

`ifdef ALU_SEQ_SHIFT_EN
        drive(1'b1, 4'hB, 32'h5, 32'd10, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rs_accept", 32'(accepted), 32'd1);
        idle(1'b1);
        idle(1'b1);
        chk("rs_busy", 32'(in_ready), 32'd0);
`else
        drive(1'b1, 4'h0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rs_accept", 32'(accepted), 32'd1);
        idle(1'b0);
        chk("rs_hold", 32'(out_valid), 32'd1);
`endif
        rst_n = 1'b0;
        idle(1'b1);
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        chk("rs_flags", 32'({z, n, c, v}), 32'd0);
        chk("rs_out", out, 32'd0);
        sb.delete();
        fz = 1'b0; fn = 1'b0; fc = 1'b0; fv = 1'b0;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            idle(1'b1);
            if (out_valid) stale++;
        end
        chk("rs_no_stale", 32'(stale), 32'd0);

        drive(1'b1, 4'h1, 32'h3, 32'h4, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_out("post_rst", 1, 1'b0);
        chk("post_rst_out", out, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational datapath ALU. It accepts one operation per transaction on a valid/ready input and returns a registered result plus Z/N/C/V flags on a valid/ready output. It keeps an architectural flag register that can feed its own carry-in. An optional iterative barrel-free shifter adds multi-cycle shift opcodes. It sits between operand fetch and writeback in the execute stage.

## Interface
- `WIDTH`, 32: operand/result width in bits (≥ 8, power of two).
- `SHW`, $clog2(WIDTH): shift-amount width, derived; do not override.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted when `in_valid && in_ready`.
- `op` in 4: opcode.
- `a`, `b` in WIDTH: operands.
- `ci` in 1: external carry-in.
- `ci_sel` in 1: 0 selects `ci` as carry-in; 1 selects stored flag C.
- `set_flags` in 1: commit this operation's flags to the flag register.
- `out_valid` out 1: result available.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out` out WIDTH: registered result.
- `z`, `n`, `c`, `v` out 1 each: flag register contents.

## Operation
- Opcodes 0000 A+B, 0001 A+B+cin, 0010 A−B, 0011 A−B−cin, 0100 B−A, 0101 OR, 0110 XOR, 0111 AND, 1000 pass A, 1001 A+8, 1010 pass B.
- Opcodes 1011 SHL, 1100 SHR, 1101 SRA shift `a` by `b[SHW-1:0]`; they exist only with the macro (see Configuration). Opcodes 1110/1111 give a result of 0.
- Arithmetic is WIDTH+1 bits wide.
  - Add C = bit WIDTH (carry out). Sub C = borrow (1 when the unsigned minuend is less than subtrahend + cin).
  - Add V = ~(a^b)&(a^out) on the MSB. Sub V = (a^b)&(a^out) on the MSB.
- Flag update, on the cycle the result is loaded, only if `set_flags` was captured:
  - Z = (out==0) and N = out[WIDTH-1] for all ops.
  - C and V are written only for ops 0000–0011.
  - Shifts write C = last bit shifted out (unchanged if shamt 0) and keep V.
  - All other ops keep C and V.
- `ci_sel=1` uses the flag C value at the time of acceptance.
- FSM states:
  - IDLE: accepts operations.
  - SHIFT: iterating a shift.
  - HOLD: `out_valid` asserted, waiting for `out_ready`.
- FSM transitions:
  - IDLE → HOLD on accept of a non-shift op, or a shift with shamt 0.
  - IDLE → SHIFT on accept of a shift with shamt>0; the shift count loads shamt.
  - SHIFT shifts one bit per cycle and decrements the count. At count 1 it loads the result and goes to HOLD.
  - HOLD → IDLE on `out_ready`. If `in_valid` is also high, it accepts the next op in the same cycle and goes straight to HOLD or SHIFT.
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready).

## Timing
- Reset values: `out`=0, `out_valid`=0, `in_ready`=1 (state IDLE), z=n=c=v=0, shift count 0.
- Latency, accept edge to `out_valid`:
  - Non-shift ops: 1 cycle.
  - Shift: shamt+1 cycles (shamt 0 → 1 cycle).
- Throughput is one non-shift op per cycle with `out_ready` held high.
- While `out_valid && !out_ready`: `out`, flags and `out_valid` hold stable and `in_ready`=0.
- Flags change only on a result-load edge; `z/n/c/v` are valid with `out` from the same edge.
- Back-to-back ops with `ci_sel=1` see the flags committed by the previous op, which has already loaded.
- Reset asserted in any state, including mid-SHIFT, returns every register to its reset value on that edge. The partial result is discarded and never presented.
- `in_valid` while not ready is ignored. Operands need not be held after acceptance.

## Configuration
- `ALU_SEQ_SHIFT_EN` defined:
  - Opcodes 1011/1100/1101 are iterative shifts as above.
  - SRA replicates the MSB; SHR/SHL fill with 0.
- Macro undefined:
  - SHIFT state and shift counter are not built.
  - 1011–1101 behave as 1110: result 0, 1-cycle latency, Z=1/N=0 if `set_flags`, C and V kept.

## Test plan
- WIDTH=32, a=0x9C000038, b=0x70000003, op 0000, set_flags=1 → out=0x0C00003B one cycle later, c=1, v=0, z=0, n=0.
- Same operands, op 0010 → out=0x2C000035, c=0, v=1, n=0. Then op 0001 with ci_sel=1 uses the stored c=0 → 0x0C00003B.
- op 0111, a=0x0F0F0F0F, b=0xF0F0F0F0, set_flags=1 → out=0, z=1, n=0, and c/v unchanged from the prior op.
- With the macro: op 1011, a=1, b=4 → out_valid 5 cycles after accept, out=0x10. op 1101, a=0x80000000, b=31 → out=0xFFFFFFFF, n=1, and in_ready=0 throughout.
- Backpressure: out_ready=0 for 3 cycles after a result → out and flags stable, in_ready=0, and the next op is accepted on the out_ready cycle.
- rst_n=0 during cycle 3 of a 10-bit shift → next cycle out_valid=0, in_ready=1, all flags 0, and no stale result appears.
